// File: rtl/uadd_5_arb.sv
// uadd_5_arb: round-robin arbiter that shares one saturating unsigned W-bit adder among N_REQ
// requesters. It returns each result over a valid/ready port and counts accepted overflowing adds.
module uadd_5_arb #(
   parameter int N_REQ = 4,
   parameter int W     = 5,
   parameter int CNT_W = 8,
   localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_i,
   input  logic [N_REQ*W-1:0] a_i,
   input  logic [N_REQ*W-1:0] b_i,
   output logic [N_REQ-1:0]   gnt_o,
   output logic               busy_o,
   output logic               res_valid_o,
   input  logic               res_ready_i,
   output logic [IDW-1:0]     res_id_o,
   output logic [W-1:0]       res_s_o,
   output logic               res_of_o,
   input  logic               of_cnt_clr_i,
   output logic [CNT_W-1:0]   of_cnt_o
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t             state_q;
   logic [IDW-1:0]     ptr_q;
   logic [IDW-1:0]     opId_q;
   logic [W-1:0]       opA_q;
   logic [W-1:0]       opB_q;
   logic [N_REQ-1:0]   gnt_q;
   logic               resValid_q;
   logic [IDW-1:0]     resId_q;
   logic [W-1:0]       resS_q;
   logic               resOf_q;
   logic [CNT_W-1:0]   ofCnt_q;

   logic [W-1:0]       aArr [N_REQ];
   logic [W-1:0]       bArr [N_REQ];
   logic [IDW-1:0]     win_d;
   logic               found_d;
   int                 idx;
   logic [N_REQ-1:0]   onehot_d;
   logic [W:0]         full_d;
   logic [W-1:0]       sat_d;
   logic               accept_d;

   for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
      assign aArr[k] = a_i[k*W +: W];
      assign bArr[k] = b_i[k*W +: W];
   end

   // Scan requesters starting at the round-robin pointer; the first one set wins.
   always_comb begin
      win_d   = '0;
      found_d = 1'b0;
      idx     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (!found_d && req_i[IDW'(idx)]) begin
            found_d = 1'b1;
            win_d   = IDW'(idx);
         end
      end
   end

   assign onehot_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_d;
   assign full_d   = {1'b0, opA_q} + {1'b0, opB_q};
   assign sat_d    = full_d[W] ? {W{1'b1}} : full_d[W-1:0];
   assign accept_d = (state_q == DONE) && res_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         opId_q     <= '0;
         opA_q      <= '0;
         opB_q      <= '0;
         gnt_q      <= '0;
         resValid_q <= 1'b0;
         resId_q    <= '0;
         resS_q     <= '0;
         resOf_q    <= 1'b0;
         ofCnt_q    <= '0;
      end else begin
         gnt_q <= '0;
         case (state_q)
            IDLE: begin
               if (found_d) begin
                  opA_q   <= aArr[win_d];
                  opB_q   <= bArr[win_d];
                  opId_q  <= win_d;
                  gnt_q   <= onehot_d;
                  ptr_q   <= (win_d == IDW'(N_REQ-1)) ? '0 : win_d + 1'b1;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               resS_q     <= sat_d;
               resOf_q    <= full_d[W];
               resId_q    <= opId_q;
               resValid_q <= 1'b1;
               state_q    <= DONE;
            end
            DONE: begin
               if (res_ready_i) begin
                  resValid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
         // A clear in the same cycle as an overflowing acceptance leaves the counter at zero.
         if (of_cnt_clr_i) begin
            ofCnt_q <= '0;
         end else if (accept_d && resOf_q && (ofCnt_q != {CNT_W{1'b1}})) begin
            ofCnt_q <= ofCnt_q + 1'b1;
         end
      end
   end

   assign gnt_o       = gnt_q;
   assign busy_o      = (state_q != IDLE);
   assign res_valid_o = resValid_q;
   assign res_id_o    = resId_q;
   assign res_s_o     = resS_q;
   assign res_of_o    = resOf_q;
   assign of_cnt_o    = ofCnt_q;

endmodule

// File: tb/tb_uadd_5_arb.sv
// tb_uadd_5_arb: randomized and directed bench for uadd_5_arb, checked against a transaction-level
// model of round-robin winner choice, saturating add and overflow counting.
module tb_uadd_5_arb;

   localparam int N     = 4;
   localparam int W     = 5;
   localparam int CNT_W = 8;
   localparam int IDW   = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     req_i;
   logic [N*W-1:0]   a_i;
   logic [N*W-1:0]   b_i;
   logic [N-1:0]     gnt_o;
   logic             busy_o;
   logic             res_valid_o;
   logic             res_ready_i;
   logic [IDW-1:0]   res_id_o;
   logic [W-1:0]     res_s_o;
   logic             res_of_o;
   logic             of_cnt_clr_i;
   logic [CNT_W-1:0] of_cnt_o;

   int errors = 0;
   int checks = 0;
   int ptrM   = 0;
   int ofCntM = 0;
   int opA [N];
   int opB [N];

   logic [N-1:0]     oGnt, oGnt2;
   int               oCyc;
   logic             oBusy, oValid, oValidAfter, oOf;
   logic [IDW-1:0]   oId;
   logic [W-1:0]     oS;
   logic [CNT_W-1:0] oCnt;

   uadd_5_arb #(.N_REQ(N), .W(W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .a_i(a_i), .b_i(b_i), .gnt_o(gnt_o),
      .busy_o(busy_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
      .res_id_o(res_id_o), .res_s_o(res_s_o), .res_of_o(res_of_o),
      .of_cnt_clr_i(of_cnt_clr_i), .of_cnt_o(of_cnt_o)
   );

   always #5 clk = ~clk;

   // Reference: first requester at or after the pointer, wrapping.
   function automatic int modelWinner(logic [N-1:0] req, int ptr);
      for (int i = 0; i < N; i++) begin
         int k = (ptr + i) % N;
         if (req[k]) return k;
      end
      return -1;
   endfunction

   function automatic int satSum(int a, int b);
      return (a + b > 31) ? 31 : a + b;
   endfunction

   task automatic modelAccept(int w);
      ptrM = (w + 1) % N;
      if (opA[w] + opB[w] > 31) ofCntM = (ofCntM < 255) ? ofCntM + 1 : 255;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setOps(int k, int a, int b);
      opA[k] = a;
      opB[k] = b;
      a_i[k*W +: W] = W'(a);
      b_i[k*W +: W] = W'(b);
   endtask

   task automatic waitGnt(output logic [N-1:0] g, output int cyc);
      g = '0;
      cyc = 0;
      while (g == '0 && cyc < 12) begin
         step();
         cyc++;
         g = gnt_o;
      end
   endtask

   // Drives one request with ready high and records what the DUT shows at each phase.
   task automatic applyStimulus(logic [N-1:0] req);
      req_i = req;
      waitGnt(oGnt, oCyc);
      oBusy = busy_o;
      req_i = '0;
      step();
      oGnt2 = gnt_o; oValid = res_valid_o; oId = res_id_o; oS = res_s_o; oOf = res_of_o;
      step();
      oValidAfter = res_valid_o;
      oCnt = of_cnt_o;
   endtask

   task automatic pulseReset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      ptrM = 0;
      ofCntM = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_i = '0; a_i = '0; b_i = '0; res_ready_i = 1'b1; of_cnt_clr_i = 1'b0;
      step(); step();
      checks++; if (gnt_o !== 4'b0) begin errors++; $display("[TB] FAIL reset_gnt: got %b want 0", gnt_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
      checks++; if (res_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", res_valid_o); end
      checks++; if (res_id_o !== 2'd0) begin errors++; $display("[TB] FAIL reset_id: got %0d want 0", res_id_o); end
      checks++; if (res_s_o !== 5'd0) begin errors++; $display("[TB] FAIL reset_s: got %0d want 0", res_s_o); end
      checks++; if (res_of_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_of: got %b want 0", res_of_o); end
      checks++; if (of_cnt_o !== 8'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d want 0", of_cnt_o); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      setOps(0, 5, 9);
      applyStimulus(4'b0001);
      modelAccept(0);
      checks++; if (oGnt !== 4'b0001) begin errors++; $display("[TB] FAIL t1_gnt: got %b want 0001", oGnt); end
      checks++; if (oCyc != 1) begin errors++; $display("[TB] FAIL t1_gnt_latency: got %0d want 1", oCyc); end
      checks++; if (oBusy !== 1'b1) begin errors++; $display("[TB] FAIL t1_busy: got %b want 1", oBusy); end
      checks++; if (oGnt2 !== 4'b0) begin errors++; $display("[TB] FAIL t1_gnt_pulse: got %b want 0", oGnt2); end
      checks++; if (oValid !== 1'b1) begin errors++; $display("[TB] FAIL t1_valid: got %b want 1", oValid); end
      checks++; if (oId !== 2'd0) begin errors++; $display("[TB] FAIL t1_id: got %0d want 0", oId); end
      checks++; if (oS !== 5'd14) begin errors++; $display("[TB] FAIL t1_sum: got %0d want 14", oS); end
      checks++; if (oOf !== 1'b0) begin errors++; $display("[TB] FAIL t1_of: got %b want 0", oOf); end
      checks++; if (oValidAfter !== 1'b0) begin errors++; $display("[TB] FAIL t1_valid_drop: got %b want 0", oValidAfter); end
      checks++; if (oCnt !== 8'd0) begin errors++; $display("[TB] FAIL t1_cnt: got %0d want 0", oCnt); end
   endtask

   task automatic test_overflow();
      setOps(2, 31, 1);
      applyStimulus(4'b0100);
      modelAccept(2);
      checks++; if (oGnt !== 4'b0100) begin errors++; $display("[TB] FAIL t2_gnt: got %b want 0100", oGnt); end
      checks++; if (oId !== 2'd2) begin errors++; $display("[TB] FAIL t2_id: got %0d want 2", oId); end
      checks++; if (oS !== 5'd31) begin errors++; $display("[TB] FAIL t2_sum: got %0d want 31", oS); end
      checks++; if (oOf !== 1'b1) begin errors++; $display("[TB] FAIL t2_of: got %b want 1", oOf); end
      checks++; if (oCnt !== 8'd1) begin errors++; $display("[TB] FAIL t2_cnt: got %0d want 1", oCnt); end
      for (int a = 0; a < 32; a++) begin
         for (int b = 0; b < 32; b++) begin
            setOps(1, a, b);
            applyStimulus(4'b0010);
            modelAccept(1);
            checks++; if (oS !== W'(satSum(a, b))) begin errors++; $display("[TB] FAIL exh_sum a=%0d b=%0d: got %0d want %0d", a, b, oS, satSum(a, b)); end
            checks++; if (oOf !== (a + b > 31)) begin errors++; $display("[TB] FAIL exh_of a=%0d b=%0d: got %b want %b", a, b, oOf, (a + b > 31)); end
            checks++; if (oId !== 2'd1) begin errors++; $display("[TB] FAIL exh_id a=%0d b=%0d: got %0d want 1", a, b, oId); end
            checks++; if (oCnt !== CNT_W'(ofCntM)) begin errors++; $display("[TB] FAIL exh_cnt a=%0d b=%0d: got %0d want %0d", a, b, oCnt, ofCntM); end
         end
      end
   endtask

   task automatic test_random();
      logic [N-1:0] req;
      int w;
      for (int t = 0; t < 40; t++) begin
         for (int k = 0; k < N; k++) setOps(k, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
         req = N'($urandom_range(1, 15));
         w = modelWinner(req, ptrM);
         applyStimulus(req);
         checks++; if (oGnt !== (N'(1) << w)) begin errors++; $display("[TB] FAIL rnd_gnt req=%b: got %b want %b", req, oGnt, N'(1) << w); end
         checks++; if (oId !== IDW'(w)) begin errors++; $display("[TB] FAIL rnd_id: got %0d want %0d", oId, w); end
         checks++; if (oS !== W'(satSum(opA[w], opB[w]))) begin errors++; $display("[TB] FAIL rnd_sum: got %0d want %0d", oS, satSum(opA[w], opB[w])); end
         modelAccept(w);
         checks++; if (oCnt !== CNT_W'(ofCntM)) begin errors++; $display("[TB] FAIL rnd_cnt: got %0d want %0d", oCnt, ofCntM); end
      end
   endtask

   task automatic test_round_robin();
      int expSeq [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
      logic [N-1:0] g;
      int c;
      for (int k = 0; k < N; k++) setOps(k, k + 1, k + 2);
      pulseReset();
      req_i = 4'b1111;
      for (int i = 0; i < 9; i++) begin
         waitGnt(g, c);
         if (i == 6) req_i = 4'b1001;
         checks++; if (g !== (N'(1) << expSeq[i])) begin errors++; $display("[TB] FAIL rr_gnt[%0d]: got %b want %b", i, g, N'(1) << expSeq[i]); end
         checks++; if (c != ((i == 0) ? 1 : 3)) begin errors++; $display("[TB] FAIL rr_spacing[%0d]: got %0d want %0d", i, c, (i == 0) ? 1 : 3); end
         modelAccept(expSeq[i]);
      end
      req_i = '0;
      step(); step();
   endtask

   task automatic test_backpressure();
      logic [N-1:0] g;
      int c, w;
      logic [IDW+W:0] held;
      res_ready_i = 1'b0;
      req_i = 4'b1111;
      w = modelWinner(4'b1111, ptrM);
      waitGnt(g, c);
      checks++; if (g !== (N'(1) << w)) begin errors++; $display("[TB] FAIL bp_gnt: got %b want %b", g, N'(1) << w); end
      step();
      held = {IDW'(w), W'(satSum(opA[w], opB[w])), 1'b0};
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if ({res_valid_o, gnt_o, busy_o, res_id_o, res_s_o, res_of_o} !== {1'b1, 4'b0, 1'b1, held}) begin
            errors++;
            $display("[TB] FAIL bp_hold[%0d]: got v=%b g=%b busy=%b id=%0d s=%0d of=%b want v=1 g=0 busy=1 id=%0d s=%0d of=0",
                     i, res_valid_o, gnt_o, busy_o, res_id_o, res_s_o, res_of_o, w, satSum(opA[w], opB[w]));
         end
      end
      res_ready_i = 1'b1;
      step();
      modelAccept(w);
      checks++; if (res_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid_drop: got %b want 0", res_valid_o); end
      w = modelWinner(4'b1111, ptrM);
      waitGnt(g, c);
      checks++; if (g !== (N'(1) << w)) begin errors++; $display("[TB] FAIL bp_next_gnt: got %b want %b", g, N'(1) << w); end
      checks++; if (c != 1) begin errors++; $display("[TB] FAIL bp_next_latency: got %0d want 1", c); end
      req_i = '0;
      step(); step();
      modelAccept(w);
   endtask

   task automatic test_reset_midflight();
      logic [N-1:0] g;
      int c;
      setOps(2, 3, 4);
      req_i = 4'b0100;
      waitGnt(g, c);
      req_i = '0;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({gnt_o, busy_o, res_valid_o, res_id_o, res_s_o, res_of_o, of_cnt_o} !== '0) begin
         errors++;
         $display("[TB] FAIL rst_exec: got g=%b busy=%b v=%b id=%0d s=%0d of=%b cnt=%0d want all 0",
                  gnt_o, busy_o, res_valid_o, res_id_o, res_s_o, res_of_o, of_cnt_o);
      end
      step();
      rst_n = 1'b1;
      ptrM = 0; ofCntM = 0;
      setOps(3, 31, 31);
      req_i = 4'b1000;
      waitGnt(g, c);
      req_i = '0;
      step();
      checks++; if (res_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_done_valid: got %b want 1", res_valid_o); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({gnt_o, busy_o, res_valid_o, res_id_o, res_s_o, res_of_o, of_cnt_o} !== '0) begin
         errors++;
         $display("[TB] FAIL rst_done: got g=%b busy=%b v=%b id=%0d s=%0d of=%b cnt=%0d want all 0",
                  gnt_o, busy_o, res_valid_o, res_id_o, res_s_o, res_of_o, of_cnt_o);
      end
      step();
      rst_n = 1'b1;
      ptrM = 0; ofCntM = 0;
      setOps(0, 1, 1);
      req_i = 4'b1111;
      waitGnt(g, c);
      checks++; if (g !== 4'b0001) begin errors++; $display("[TB] FAIL rst_first_gnt: got %b want 0001", g); end
      req_i = '0;
      step(); step();
      modelAccept(0);
   endtask

   task automatic test_counter();
      logic [N-1:0] g;
      int c, a;
      of_cnt_clr_i = 1'b1;
      step();
      of_cnt_clr_i = 1'b0;
      ofCntM = 0;
      checks++; if (of_cnt_o !== 8'd0) begin errors++; $display("[TB] FAIL cnt_clear: got %0d want 0", of_cnt_o); end
      for (int i = 0; i < 257; i++) begin
         a = int'($urandom_range(1, 31));
         setOps(0, a, int'($urandom_range(32 - a, 31)));
         applyStimulus(4'b0001);
         modelAccept(0);
         if (i == 0 || i == 253 || i == 256) begin
            checks++; if (oCnt !== CNT_W'(ofCntM)) begin errors++; $display("[TB] FAIL cnt_step[%0d]: got %0d want %0d", i, oCnt, ofCntM); end
         end
      end
      checks++; if (of_cnt_o !== 8'd255) begin errors++; $display("[TB] FAIL cnt_saturate: got %0d want 255", of_cnt_o); end
      setOps(0, 31, 31);
      req_i = 4'b0001;
      waitGnt(g, c);
      req_i = '0;
      step();
      checks++; if ({res_valid_o, res_of_o} !== 2'b11) begin errors++; $display("[TB] FAIL cnt_pre_clr: got v=%b of=%b want 1 1", res_valid_o, res_of_o); end
      of_cnt_clr_i = 1'b1;
      step();
      of_cnt_clr_i = 1'b0;
      ptrM = 1;
      ofCntM = 0;
      checks++; if (of_cnt_o !== 8'd0) begin errors++; $display("[TB] FAIL cnt_clr_wins: got %0d want 0", of_cnt_o); end
      checks++; if (res_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL cnt_clr_accept: got %b want 0", res_valid_o); end
      applyStimulus(4'b0001);
      modelAccept(0);
      checks++; if (oCnt !== CNT_W'(ofCntM)) begin errors++; $display("[TB] FAIL cnt_after_clr: got %0d want %0d", oCnt, ofCntM); end
   endtask

   task automatic checkOutput();
      $display("Result: errors=%0d of %0d checks", errors, checks);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_random();
      test_round_robin();
      test_backpressure();
      test_reset_midflight();
      test_counter();
      checkOutput();
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
